isa_test_monitor: RTL

Parametrised commit monitor for the ISA test bench; successor to the fixed-address bench scoreboard. Watches the core's debug PC and instruction-valid strobe, captures console characters written at a configurable print PC into a FIFO, and drains them over a valid/ready port. Tracks pass, fail and timeout termination, and counts committed instructions. Sits beside the DUT in the bench, and is synthesisable for on-board self-test.

---
 rtl/isa_test_monitor.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/isa_test_monitor.sv
`default_nettype none
// ============================================================================
// Module      : isa_test_monitor
// Description : Commit monitor for ISA tests. Captures console characters into
//               a FIFO and tracks pass, fail and watchdog termination.
// Revision    : 1.0 - initial release
// ============================================================================
module isa_test_monitor #(
    parameter logic [31:0] PRINT_PC  = 32'h18,
    parameter logic [31:0] END_PC    = 32'h1c,
    parameter logic [31:0] FAIL_PC   = 32'h20,
    parameter int          BUF_DEPTH = 16,
    parameter int          TIMEOUT   = 100000,
    parameter int          CNT_W     = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [31:0]      i_pc_debug,
    input  logic             i_insn_vld,
    input  logic [31:0]      i_char_src,
    output logic [7:0]       o_char,
    output logic             o_char_vld,
    input  logic             i_char_rdy,
    output logic [CNT_W-1:0] o_insn_cnt,
    output logic [15:0]      o_char_cnt,
    output logic             o_pass,
    output logic             o_fail,
    output logic             o_timeout,
    output logic             o_overflow,
    output logic             o_finished
);

    localparam int c_ptr_w = $clog2(BUF_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_wd_w  = $clog2(TIMEOUT + 1);

    localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(BUF_DEPTH);
    localparam logic [c_wd_w-1:0]  c_wd_last = c_wd_w'(TIMEOUT - 1);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_run     = 3'd1;
    localparam logic [2:0] c_st_pass    = 3'd2;
    localparam logic [2:0] c_st_fail    = 3'd3;
    localparam logic [2:0] c_st_timeout = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_state_next;
    logic [c_wd_w-1:0]  r_wd;
    logic [c_wd_w-1:0]  w_wd_next;

    logic [7:0]         r_mem [BUF_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] w_rd_next;
    logic [c_cnt_w-1:0] r_count;
    logic [c_cnt_w-1:0] w_count_next;

    logic [7:0]         r_char;
    logic [7:0]         w_head_next;
    logic               r_char_vld;
    logic [CNT_W-1:0]   r_insn_cnt;
    logic [15:0]        r_char_cnt;
    logic               r_pass;
    logic               r_fail;
    logic               r_timeout;
    logic               r_overflow;
    logic               r_finished;

    logic               w_active;
    logic               w_commit;
    logic               w_capture;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic               w_term_next;
    logic               w_unused_src;

    assign w_unused_src = ^i_char_src[31:8];

    assign w_active  = (r_state == c_st_idle) || (r_state == c_st_run);
    assign w_commit  = w_active && i_insn_vld;
    assign w_capture = w_commit && (i_pc_debug == PRINT_PC);
    assign w_full    = (r_count == c_depth);
    assign w_pop     = r_char_vld && i_char_rdy;
    assign w_push    = w_capture && (!w_full || w_pop);
    assign w_drop    = w_capture && w_full && !w_pop;

    // Commit in IDLE is handled exactly like a RUN commit; FAIL_PC wins over END_PC.
    always_comb begin
        w_state_next = r_state;
        w_wd_next    = r_wd;
        case (r_state)
            c_st_idle, c_st_run: begin
                if (i_insn_vld) begin
                    w_wd_next = '0;
                    if (i_pc_debug == FAIL_PC) begin
                        w_state_next = c_st_fail;
                    end else if (i_pc_debug == END_PC) begin
                        w_state_next = c_st_pass;
                    end else begin
                        w_state_next = c_st_run;
                    end
                end else if (r_state == c_st_run) begin
                    if (r_wd == c_wd_last) begin
                        w_state_next = c_st_timeout;
                    end else begin
                        w_wd_next = r_wd + c_wd_w'(1);
                    end
                end else begin
                    w_wd_next = '0;
                end
            end
            default: begin
                w_wd_next = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= c_st_idle;
            r_wd    <= '0;
        end else begin
            r_state <= w_state_next;
            r_wd    <= w_wd_next;
        end
    end

    assign w_term_next = (w_state_next == c_st_pass) || (w_state_next == c_st_fail) ||
                         (w_state_next == c_st_timeout);

    always_comb begin
        w_rd_next = w_pop ? r_rd_ptr + c_ptr_w'(1) : r_rd_ptr;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + c_cnt_w'(1);
            2'b01:   w_count_next = r_count - c_cnt_w'(1);
            default: w_count_next = r_count;
        endcase
    end

    // A lone entry after this edge is the one being written now, so bypass the array.
    always_comb begin
        w_head_next = r_char;
        if (w_push && (w_count_next == c_cnt_w'(1))) begin
            w_head_next = i_char_src[7:0];
        end else if (w_count_next != '0) begin
            w_head_next = r_mem[w_rd_next];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset && w_push) begin
            r_mem[r_wr_ptr] <= i_char_src[7:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_char     <= '0;
            r_char_vld <= 1'b0;
            r_insn_cnt <= '0;
            r_char_cnt <= '0;
            r_pass     <= 1'b0;
            r_fail     <= 1'b0;
            r_timeout  <= 1'b0;
            r_overflow <= 1'b0;
            r_finished <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            r_rd_ptr   <= w_rd_next;
            r_count    <= w_count_next;
            r_char     <= w_head_next;
            r_char_vld <= (w_count_next != '0);
            if (w_commit) begin
                r_insn_cnt <= r_insn_cnt + CNT_W'(1);
            end
            if (w_capture && (r_char_cnt != 16'hFFFF)) begin
                r_char_cnt <= r_char_cnt + 16'd1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            r_pass     <= (w_state_next == c_st_pass);
            r_fail     <= (w_state_next == c_st_fail);
            r_timeout  <= (w_state_next == c_st_timeout);
            r_finished <= w_term_next && (w_count_next == '0);
        end
    end

    assign o_char     = r_char;
    assign o_char_vld = r_char_vld;
    assign o_insn_cnt = r_insn_cnt;
    assign o_char_cnt = r_char_cnt;
    assign o_pass     = r_pass;
    assign o_fail     = r_fail;
    assign o_timeout  = r_timeout;
    assign o_overflow = r_overflow;
    assign o_finished = r_finished;

endmodule
`default_nettype wire
